// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions: op codes and FSM state encoding.
// Optional divide build: SEQ_ALU_DIV_EN.
package seq_alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_iter_op(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative shift-add multiply / restoring divide datapath.
// Divide path only present with SEQ_ALU_DIV_EN.
module seq_alu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_step,
`ifdef SEQ_ALU_DIV_EN
  input  logic             i_div,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [CNT_W-1:0] o_cnt,
  output logic [WIDTH-1:0] o_lo_nxt,
  output logic [WIDTH-1:0] o_hi_nxt
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   w_add;

  // mul: {hi,lo} shifts right; lo holds the remaining multiplier bits
  assign w_add = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};

`ifdef SEQ_ALU_DIV_EN
  logic             r_div;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_dif;

  // div: {hi,lo} shifts left; a zero divisor yields all-ones / dividend
  assign w_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_dif = w_sh - {1'b0, r_b};
`endif

  always_comb begin
    o_hi_nxt = w_add[WIDTH:1];
    o_lo_nxt = {w_add[0], r_lo[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    if (r_div) begin
      if (!w_dif[WIDTH]) begin
        o_hi_nxt = w_dif[WIDTH-1:0];
        o_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        o_hi_nxt = w_sh[WIDTH-1:0];
        o_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_cnt <= '0;
`ifdef SEQ_ALU_DIV_EN
      r_div <= 1'b0;
`endif
    end else if (i_start) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_b   <= i_b;
      r_cnt <= CNT_W'(WIDTH);
`ifdef SEQ_ALU_DIV_EN
      r_div <= i_div;
`endif
    end else if (i_step) begin
      r_hi  <= o_hi_nxt;
      r_lo  <= o_lo_nxt;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_alu.sv
// WIDTH-bit sequential ALU: single-cycle logic/arith/compare plus
// iterative MUL (and DIV when SEQ_ALU_DIV_EN is defined).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             cout_o,
  output logic             illegal_o
);

  logic [1:0]       r_state;
  logic             r_valid;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_hi;
  logic             r_zero;
  logic             r_ovf;
  logic             r_cout;
  logic             r_ill;

  logic             w_acc;
  logic             w_iter;
  logic             w_sub;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf_f;
  logic             w_cout_f;
  logic             w_ill;
  logic [CNT_W-1:0] w_cnt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_hi_nxt;

  assign in_ready_o = (r_state == ST_IDLE);
  assign w_acc      = in_valid_i & in_ready_o;
  assign w_iter     = is_iter_op(op_i);

  assign w_sub = (op_i == OP_SUB) || (op_i == OP_SLT);
  assign w_bx  = w_sub ? ~src2_i : src2_i;
  assign w_sum = {1'b0, src1_i} + {1'b0, w_bx}
               + {{WIDTH{1'b0}}, w_sub};
  assign w_ovf = (src1_i[WIDTH-1] == w_bx[WIDTH-1])
               & (w_sum[WIDTH-1] != src1_i[WIDTH-1]);

  always_comb begin
    w_res    = '0;
    w_ovf_f  = 1'b0;
    w_cout_f = 1'b0;
    w_ill    = 1'b0;
    case (op_i)
      OP_AND: w_res = src1_i & src2_i;
      OP_OR:  w_res = src1_i | src2_i;
      OP_NOR: w_res = ~(src1_i | src2_i);
      OP_ADD, OP_SUB: begin
        w_res    = w_sum[WIDTH-1:0];
        w_ovf_f  = w_ovf;
        w_cout_f = w_sum[WIDTH];
      end
      OP_SLT:
        w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
      default: w_ill = ~w_iter;
    endcase
  end

  seq_alu_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_start  (w_acc & w_iter),
    .i_step   (r_state != ST_IDLE),
`ifdef SEQ_ALU_DIV_EN
    .i_div    (op_i == OP_DIV),
`endif
    .i_a      (src1_i),
    .i_b      (src2_i),
    .o_cnt    (w_cnt),
    .o_lo_nxt (w_lo_nxt),
    .o_hi_nxt (w_hi_nxt)
  );

  // DONE performs the final step and registers its result directly
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_res   <= '0;
      r_hi    <= '0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cout  <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            if (w_iter) begin
              r_state <= ST_ITER;
            end else begin
              r_valid <= 1'b1;
              r_res   <= w_res;
              r_hi    <= '0;
              r_zero  <= (w_res == '0);
              r_ovf   <= w_ovf_f;
              r_cout  <= w_cout_f;
              r_ill   <= w_ill;
            end
          end
        end
        ST_ITER: begin
          if (w_cnt == CNT_W'(2)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b1;
          r_res   <= w_lo_nxt;
          r_hi    <= w_hi_nxt;
          r_zero  <= (w_lo_nxt == '0);
          r_ovf   <= 1'b0;
          r_cout  <= 1'b0;
          r_ill   <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid_o = r_valid;
  assign result_o    = r_res;
  assign hi_o        = r_hi;
  assign zero_o      = r_zero;
  assign overflow_o  = r_ovf;
  assign cout_o      = r_cout;
  assign illegal_o   = r_ill;

endmodule
